trail_compositor: RTL
=====================

Name: trail_compositor

Overview:
- Parametrised successor to the two-player frame-buffer/bike compositor.
- Pipelined pixel path:
  - generates frame-RAM read addresses from DrawX/DrawY;
  - extracts the packed trail pixel;
  - overlays NUM_PLAYERS bike sprites by fixed priority;
  - emits color_enum to the palette.
- Accumulates per-player collisions over a frame (sprite-on-trail and sprite-on-sprite) and publishes them once per frame_clk with a valid/ack handshake and an overrun flag.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines
- PIX_PER_WORD, 2, pixels per RAM word; power of 2
- COLOR_W, 4, colour index width
- NUM_PLAYERS, 2, number of bike sprites/collision channels
- ADDR_W, 19, frame-RAM address width
- BG_COLOR, 4'h8, colour meaning empty trail cell
- SPRITE_TRANSPARENT, 4'hF, sprite value meaning no bike pixel

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  frame tick (~60 Hz), same-domain slow signal
- enable  in  1  collision accumulation enable
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- Sprite_Color  in  NUM_PLAYERS*COLOR_W  player p sprite pixel at DrawX/DrawY, slice [p*COLOR_W +: COLOR_W]
- ram_read_address  out  ADDR_W  frame-RAM read address
- ram_data_out  in  8*PIX_PER_WORD  frame-RAM read data; 1-cycle synchronous read
- color_enum  out  COLOR_W  composited palette index
- pixel_valid  out  1  color_enum corresponds to an active pixel
- collision  out  NUM_PLAYERS  per-player collision report
- collision_valid  out  1  report pending
- collision_ack  in  1  consumer accepts report
- overrun  out  1  sticky: a report was overwritten unacknowledged

Behaviour:
- Reset low (asynchronous):
  - all outputs and pipeline registers are 0: color_enum=0, pixel_valid=0, collision=0, collision_valid=0, overrun=0, ram_read_address=0;
  - pending flags are cleared;
  - FSM enters SCAN.
- Stage 0 (cycle t):
  - active = DrawX<H_RES && DrawY<V_RES;
  - register ram_read_address = DrawX/PIX_PER_WORD + DrawY*(H_RES/PIX_PER_WORD), zero-extended to ADDR_W;
  - register slot = DrawX%PIX_PER_WORD, active and Sprite_Color.
- Stage 1 (t+1): RAM is presented the address; sideband delayed one more register.
- Stage 2 (t+2, output registered, visible t+3, latency 3 clocks):
  - Trail pixel = ram_data_out[8k +: COLOR_W], with k = PIX_PER_WORD-1-slot. Slot 0 is the most significant byte.
  - Sprite priority: colour of the lowest-index player whose sprite != SPRITE_TRANSPARENT; otherwise the trail pixel.
  - Inactive pixel: color_enum=0 and pixel_valid=0.
- Collision detection, evaluated at stage 2 only when active && enable. Player p hit when its sprite != SPRITE_TRANSPARENT and either:
  - trail != BG_COLOR, or
  - any other player's sprite != SPRITE_TRANSPARENT at the same pixel.
  - Hit sets pending[p].
- frame_clk handling: 2-flop synchroniser plus rising-edge detect produces a 1-cycle tick.
- FSM:
  - SCAN: accumulate pending. On tick go to PUBLISH.
  - PUBLISH (1 cycle): collision <= pending; pending cleared; collision_valid <= 1; return to SCAN.
    - Hits detected during the PUBLISH cycle go into the new pending and are not lost.
    - If collision_valid was 1 and collision_ack was 0 that cycle, set overrun.
    - Publish occurs even if pending=0 (empty report).
- Handshake:
  - collision_valid && collision_ack clears collision_valid; collision holds its value.
  - Ack coinciding with PUBLISH: the old report counts as accepted, no overrun; the new report is valid.
  - Ack while not valid is ignored.
- overrun is cleared only by reset.
- enable low: pending is frozen (no new hits); publishing continues.
- Reset mid-frame or mid-handshake: everything returns to reset values; the next report reflects hits after release only.

Test Plan:
- Reset low mid-scan with pending=2'b11 and collision_valid=1 -> all outputs 0 on the next sample, and the first report after a tick is 2'b00.
- DrawX=5, DrawY=2; RAM returns 16'h0A03 one cycle after address; sprites all 4'hF -> ram_read_address=642, color_enum=4'h3 three clocks later, pixel_valid=1. Repeat with DrawX=4 -> color_enum=4'hA.
- Sprite_Color={4'h2,4'h6} (p1=2, p0=6) on trail 4'h8 -> color_enum=4'h6. Both sprites overlap, so after a frame_clk tick collision=2'b11 and collision_valid=1.
- Player 1 sprite 4'h2 over trail 4'h5, enable=1 -> collision=2'b10 after tick. Same stimulus with enable=0 -> collision=2'b00.
- Two ticks with no ack between -> overrun=1 and collision holds the second report. Repeat with ack asserted on the PUBLISH cycle -> overrun stays 0.
- DrawX=640 or DrawY=480 -> pixel_valid=0, color_enum=0, and no collision recorded despite non-transparent sprites.

Source files
------------

// File: rtl/trail_compositor_if.sv
// Pixel, frame-RAM and collision-report signals of the trail compositor.
// master = environment (raster/RAM/consumer), slave = compositor.
interface trail_compositor_if #(
  parameter int COLOR_W      = 4,
  parameter int NUM_PLAYERS  = 2,
  parameter int ADDR_W       = 19,
  parameter int PIX_PER_WORD = 2
);
  logic                           frame_clk;
  logic                           enable;
  logic [9:0]                     DrawX;
  logic [9:0]                     DrawY;
  logic [NUM_PLAYERS*COLOR_W-1:0] Sprite_Color;
  logic [ADDR_W-1:0]              ram_read_address;
  logic [8*PIX_PER_WORD-1:0]      ram_data_out;
  logic [COLOR_W-1:0]             color_enum;
  logic                           pixel_valid;
  logic [NUM_PLAYERS-1:0]         collision;
  logic                           collision_valid;
  logic                           collision_ack;
  logic                           overrun;

  modport master (
    output frame_clk, enable, DrawX, DrawY, Sprite_Color, ram_data_out, collision_ack,
    input  ram_read_address, color_enum, pixel_valid, collision, collision_valid, overrun
  );

  modport slave (
    input  frame_clk, enable, DrawX, DrawY, Sprite_Color, ram_data_out, collision_ack,
    output ram_read_address, color_enum, pixel_valid, collision, collision_valid, overrun
  );
endinterface

// File: rtl/trail_compositor.sv
// Trail/sprite compositor with per-frame collision reports; pixel latency 3 clocks.
// No pixel backpressure; an unacked report is overwritten at the next frame tick and flags overrun.
module trail_compositor #(
  parameter int                 H_RES              = 640,
  parameter int                 V_RES              = 480,
  parameter int                 PIX_PER_WORD       = 2,
  parameter int                 COLOR_W            = 4,
  parameter int                 NUM_PLAYERS        = 2,
  parameter int                 ADDR_W             = 19,
  parameter logic [COLOR_W-1:0] BG_COLOR           = 4'h8,
  parameter logic [COLOR_W-1:0] SPRITE_TRANSPARENT = 4'hF
) (
  input logic               Clk,
  input logic               Reset,
  trail_compositor_if.slave bus
);

  localparam int SLOT_W     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int SPR_W      = NUM_PLAYERS * COLOR_W;
  localparam int LINE_WORDS = H_RES / PIX_PER_WORD;

  typedef enum logic [0:0] {SCAN, PUBLISH} state_t;

  // stage 0: raster position to RAM word address and byte slot
  logic              active0;
  logic [ADDR_W-1:0] addr0;
  logic [SLOT_W-1:0] slot0;

  always_comb begin
    active0 = (int'(bus.DrawX) < H_RES) && (int'(bus.DrawY) < V_RES);
    addr0   = ADDR_W'(int'(bus.DrawX) / PIX_PER_WORD + int'(bus.DrawY) * LINE_WORDS);
    slot0   = SLOT_W'(int'(bus.DrawX) % PIX_PER_WORD);
  end

  logic [ADDR_W-1:0] addr1;
  logic [SLOT_W-1:0] slot1, slot2;
  logic              active1, active2;
  logic [SPR_W-1:0]  spr1, spr2;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr1   <= '0;
      slot1   <= '0;
      active1 <= 1'b0;
      spr1    <= '0;
      slot2   <= '0;
      active2 <= 1'b0;
      spr2    <= '0;
    end else begin
      addr1   <= addr0;
      slot1   <= slot0;
      active1 <= active0;
      spr1    <= bus.Sprite_Color;
      slot2   <= slot1;
      active2 <= active1;
      spr2    <= spr1;
    end
  end

  assign bus.ram_read_address = addr1;

  // stage 2: RAM data lines up with the twice-delayed sideband; slot 0 is the top byte
  logic [COLOR_W-1:0] trail;

  always_comb begin
    trail = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (int'(slot2) == PIX_PER_WORD - 1 - i) begin
        trail = bus.ram_data_out[8*i +: COLOR_W];
      end
    end
  end

  // walk from the highest index down so the lowest opaque player wins
  logic [NUM_PLAYERS-1:0] opaque;
  logic [COLOR_W-1:0]     mix;

  always_comb begin
    opaque = '0;
    mix    = trail;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      opaque[p] = (spr2[p*COLOR_W +: COLOR_W] != SPRITE_TRANSPARENT);
      if (opaque[p]) begin
        mix = spr2[p*COLOR_W +: COLOR_W];
      end
    end
  end

  logic                   scan_en;
  logic [NUM_PLAYERS-1:0] hit;

  always_comb begin
    scan_en = active2 && bus.enable;
    hit     = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      hit[p] = scan_en && opaque[p] &&
               ((trail != BG_COLOR) || (|(opaque & ~(NUM_PLAYERS'(1) << p))));
    end
  end

  logic [COLOR_W-1:0] color_q;
  logic               pixel_valid_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      color_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      color_q       <= active2 ? mix : '0;
      pixel_valid_q <= active2;
    end
  end

  assign bus.color_enum  = color_q;
  assign bus.pixel_valid = pixel_valid_q;

  // frame_clk is slow but asynchronous to the pixel raster phase
  logic fc_s1, fc_s2, fc_s3;
  logic tick;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fc_s1 <= 1'b0;
      fc_s2 <= 1'b0;
      fc_s3 <= 1'b0;
    end else begin
      fc_s1 <= bus.frame_clk;
      fc_s2 <= fc_s1;
      fc_s3 <= fc_s2;
    end
  end

  assign tick = fc_s2 && !fc_s3;

  state_t state, state_nxt;
  logic   publish;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= SCAN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    case (state)
      SCAN: begin
        if (tick) begin
          state_nxt = PUBLISH;
        end
      end
      PUBLISH: begin
        publish   = 1'b1;
        state_nxt = SCAN;
      end
      default: state_nxt = SCAN;
    endcase
  end

  logic [NUM_PLAYERS-1:0] pending;
  logic [NUM_PLAYERS-1:0] collision_q;
  logic                   collision_valid_q;
  logic                   overrun_q;

  // hits seen in the publish cycle seed the next frame instead of being dropped
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pending           <= '0;
      collision_q       <= '0;
      collision_valid_q <= 1'b0;
      overrun_q         <= 1'b0;
    end else if (publish) begin
      collision_q       <= pending;
      pending           <= hit;
      collision_valid_q <= 1'b1;
      if (collision_valid_q && !bus.collision_ack) begin
        overrun_q <= 1'b1;
      end
    end else begin
      pending <= pending | hit;
      if (collision_valid_q && bus.collision_ack) begin
        collision_valid_q <= 1'b0;
      end
    end
  end

  assign bus.collision       = collision_q;
  assign bus.collision_valid = collision_valid_q;
  assign bus.overrun         = overrun_q;

endmodule
